spi_accel_responder: RTL and testbench

SPI responder (slave) model of the 3-axis accelerometer that the sensor-init/readout sequencer talks to. It sits on the far side of the 4-wire SPI bus from the SPI master, decodes command bytes, holds a small control register file, and returns WHO_AM_I and axis output data. All SPI pins are oversampled in the clk_in domain, so the block is fully synchronous. It is used in cosim and as an FPGA loopback target.

---
 rtl/spi_accel_responder_pkg.sv | 21 ++
 rtl/spi_accel_responder_pin_sync.sv | 47 ++++
 rtl/spi_accel_responder.sv | 167 ++++++++++++++++
 tb/tb_spi_accel_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_responder_pkg.sv
// Shared definitions for the accelerometer SPI responder: register map,
// command-byte layout and FSM encoding.
package spi_accel_responder_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
  localparam logic [5:0] ADDR_TEMP_CFG = 6'h1F;
  localparam logic [5:0] ADDR_CTRL1    = 6'h20;
  localparam logic [5:0] ADDR_CTRL4    = 6'h23;
  localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MS_BIT = 6;
  localparam int CTRL4_BDU_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/spi_accel_responder_pin_sync.sv
// Oversamples the SPI pins into clk_in and derives single-cycle edge events.
// SCK edges are suppressed while the synchronised chip select is high.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
  logic sck_s, sck_d, cs_d;

  // Reset to bus-idle levels so no spurious edge appears on release.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      sck_q  <= '1;
      cs_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b1;
      cs_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sck_d  <= sck_s;
      cs_d   <= cs_n_s;
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign cs_n_s   = cs_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise = ~cs_n_s & sck_s & ~sck_d;
  assign sck_fall = ~cs_n_s & ~sck_s & sck_d;
  assign cs_rise  = cs_n_s & ~cs_d;
  assign cs_fall  = ~cs_n_s & cs_d;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder modelling a 3-axis accelerometer: command decode,
// control register file, WHO_AM_I and axis output shadow with BDU support.
module spi_accel_responder
  import spi_accel_responder_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        nrst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  ctrl_reg1,
  output logic [7:0]  temp_cfg,
  output logic [7:0]  ctrl_reg4,
  output logic        frame_done
);

  logic cs_n_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;
  state_e state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  byte_in;
  logic [6:0]  shift_out;
  logic [5:0]  addr;
  logic        rd_frame, inc_mode, byte_done;
  logic [7:0]  rd_data;
  logic [15:0] out_x, out_y, out_z, pend_x, pend_y, pend_z;
  logic        pend;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in  (clk_in),
    .nrst    (nrst),
    .spi_sck (spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .cs_n_s  (cs_n_s),
    .mosi_s  (mosi_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_rise (cs_rise),
    .cs_fall (cs_fall)
  );

  assign byte_in     = {shift_in, mosi_s};
  assign byte_done   = sck_rise && (bit_cnt == 3'd7);
  assign spi_miso_oe = (state == ST_DATA) && rd_frame;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
      ST_CMD:  if (byte_done) state_nxt = ST_DATA;
      ST_DATA: state_nxt = ST_DATA;
      default: state_nxt = ST_IDLE;
    endcase
    if (cs_rise) state_nxt = ST_IDLE;
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_WHO_AM_I:        rd_data = WHO_AM_I_VAL;
      ADDR_TEMP_CFG:        rd_data = temp_cfg;
      ADDR_CTRL1:           rd_data = ctrl_reg1;
      ADDR_CTRL4:           rd_data = ctrl_reg4;
      ADDR_OUT_X_L:         rd_data = out_x[7:0];
      ADDR_OUT_X_L + 6'd1:  rd_data = out_x[15:8];
      ADDR_OUT_X_L + 6'd2:  rd_data = out_y[7:0];
      ADDR_OUT_X_L + 6'd3:  rd_data = out_y[15:8];
      ADDR_OUT_X_L + 6'd4:  rd_data = out_z[7:0];
      ADDR_OUT_X_L + 6'd5:  rd_data = out_z[15:8];
      default:              rd_data = 8'h00;
    endcase
  end

  // Shift, command latch, register commit and MISO shifter.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      addr       <= '0;
      rd_frame   <= 1'b0;
      inc_mode   <= 1'b0;
      spi_miso   <= 1'b0;
      ctrl_reg1  <= 8'h07;
      temp_cfg   <= 8'h00;
      ctrl_reg4  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= cs_rise;
      if (cs_rise || cs_fall) begin
        bit_cnt <= '0;
      end else if (sck_rise && state != ST_IDLE) begin
        shift_in <= byte_in[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done && state == ST_CMD) begin
          rd_frame <= byte_in[CMD_RW_BIT];
          inc_mode <= byte_in[CMD_MS_BIT];
          addr     <= byte_in[5:0];
        end else if (byte_done && state == ST_DATA) begin
          if (!rd_frame) begin
            case (addr)
              ADDR_TEMP_CFG: temp_cfg  <= byte_in;
              ADDR_CTRL1:    ctrl_reg1 <= byte_in;
              ADDR_CTRL4:    ctrl_reg4 <= byte_in;
              default:       ;
            endcase
          end
          if (inc_mode) addr <= addr + 6'd1;
        end
      end
      // bit_cnt is 0 on the first falling edge of each data byte: reload.
      if (sck_fall && state == ST_DATA && rd_frame) begin
        if (bit_cnt == 3'd0) begin
          spi_miso  <= rd_data[7];
          shift_out <= rd_data[6:0];
        end else begin
          spi_miso  <= shift_out[6];
          shift_out <= {shift_out[5:0], 1'b0};
        end
      end
    end
  end

  // With BDU set, samples arriving inside a frame wait for cs_n to rise.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      out_x  <= '0;
      out_y  <= '0;
      out_z  <= '0;
      pend_x <= '0;
      pend_y <= '0;
      pend_z <= '0;
      pend   <= 1'b0;
    end else if (sample_valid && (!ctrl_reg4[CTRL4_BDU_BIT] || cs_n_s)) begin
      out_x <= sample_x;
      out_y <= sample_y;
      out_z <= sample_z;
      pend  <= 1'b0;
    end else if (sample_valid) begin
      pend_x <= sample_x;
      pend_y <= sample_y;
      pend_z <= sample_z;
      pend   <= 1'b1;
    end else if (pend && cs_rise) begin
      out_x <= pend_x;
      out_y <= pend_y;
      out_z <= pend_z;
      pend  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: register write/readback table plus
// hand sequences for auto-increment, BDU, partial bytes, empty frame, reset.
module tb_spi_accel_responder;

  logic        clk_in = 1'b0;
  logic        nrst;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic [7:0]  ctrl_reg1, temp_cfg, ctrl_reg4;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  spi_accel_responder #(.WHO_AM_I_VAL(8'h33), .SYNC_STAGES(2)) dut (
    .clk_in      (clk_in),
    .nrst        (nrst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .sample_x    (sample_x),
    .sample_y    (sample_y),
    .sample_z    (sample_z),
    .sample_valid(sample_valid),
    .ctrl_reg1   (ctrl_reg1),
    .temp_cfg    (temp_cfg),
    .ctrl_reg4   (ctrl_reg4),
    .frame_done  (frame_done)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (frame_done) fd_cnt <= fd_cnt + 1;

  typedef struct {
    logic [7:0] wcmd;
    logic [7:0] wdata;
    logic [7:0] rcmd;
    logic [7:0] rexp;
    logic [7:0] c1;
    logic [7:0] tc;
    logic [7:0] c4;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Mode 3 master: drive on falling, sample MISO just before rising.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                      output logic oe_or, output logic oe_and);
    rx = 8'h00;
    oe_or = 1'b0;
    oe_and = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[7-i];
      wait_clk(8);
      rx     = {rx[6:0], spi_miso};
      oe_or  = oe_or | spi_miso_oe;
      oe_and = oe_and & spi_miso_oe;
      spi_sck = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    logic oe_or, oe_and, oe_w;
    int fd0;

    vecs[0] = '{8'h20, 8'h77, 8'hA0, 8'h77, 8'h77, 8'h00, 8'h00, "ctrl1_rw"};
    vecs[1] = '{8'h1F, 8'h5A, 8'h9F, 8'h5A, 8'h77, 8'h5A, 8'h00, "temp_cfg_rw"};
    vecs[2] = '{8'h23, 8'h01, 8'hA3, 8'h01, 8'h77, 8'h5A, 8'h01, "ctrl4_rw"};
    vecs[3] = '{8'h0F, 8'h55, 8'h8F, 8'h33, 8'h77, 8'h5A, 8'h01, "whoami_ro"};
    vecs[4] = '{8'h10, 8'hAA, 8'h90, 8'h00, 8'h77, 8'h5A, 8'h01, "unmapped"};
    vecs[5] = '{8'h2A, 8'h11, 8'hAA, 8'h00, 8'h77, 8'h5A, 8'h01, "out_y_l_ro"};

    nrst = 1'b0;
    spi_sck = 1'b1;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    sample_x = '0;
    sample_y = '0;
    sample_z = '0;
    sample_valid = 1'b0;
    wait_clk(3);
    nrst = 1'b1;
    wait_clk(4);

    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_ctrl1", {24'd0, ctrl_reg1}, 32'h07);
    check("rst_temp", {24'd0, temp_cfg}, 32'h00);
    check("rst_ctrl4", {24'd0, ctrl_reg4}, 32'h00);
    check("rst_fdone", {31'd0, frame_done}, 32'd0);

    // WHO_AM_I read with frame_done count
    fd0 = fd_cnt;
    cs_start();
    xfer(8'h8F, 8, rx, oe_or, oe_and);
    check("whoami_cmd_oe", {31'd0, oe_or}, 32'd0);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("whoami_data", {24'd0, rx}, 32'h33);
    check("whoami_data_oe", {31'd0, oe_and}, 32'd1);
    cs_end();
    check("whoami_fdone", fd_cnt, fd0 + 1);

    for (int v = 0; v < 6; v++) begin
      cs_start();
      xfer(vecs[v].wcmd, 8, rx, oe_or, oe_and);
      oe_w = oe_or;
      xfer(vecs[v].wdata, 8, rx, oe_or, oe_and);
      oe_w = oe_w | oe_or;
      cs_end();
      check({vecs[v].name, "_wr_oe"}, {31'd0, oe_w}, 32'd0);
      check({vecs[v].name, "_ctrl1"}, {24'd0, ctrl_reg1}, {24'd0, vecs[v].c1});
      check({vecs[v].name, "_temp"}, {24'd0, temp_cfg}, {24'd0, vecs[v].tc});
      check({vecs[v].name, "_ctrl4"}, {24'd0, ctrl_reg4}, {24'd0, vecs[v].c4});
      cs_start();
      xfer(vecs[v].rcmd, 8, rx, oe_or, oe_and);
      check({vecs[v].name, "_rcmd_oe"}, {31'd0, oe_or}, 32'd0);
      xfer(8'h00, 8, rx, oe_or, oe_and);
      check({vecs[v].name, "_rd"}, {24'd0, rx}, {24'd0, vecs[v].rexp});
      check({vecs[v].name, "_rd_oe"}, {31'd0, oe_and}, 32'd1);
      cs_end();
    end

    // Auto-increment burst read, BDU off
    pulse_sample(16'h129A, 16'h3456, 16'h789A);
    wait_clk(2);
    cs_start();
    xfer(8'hE8, 8, rx, oe_or, oe_and);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("burst_x_l", {24'd0, rx}, 32'h9A);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("burst_x_h", {24'd0, rx}, 32'h12);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("burst_y_l", {24'd0, rx}, 32'h56);
    cs_end();

    // BDU: mid-frame sample is deferred to cs_n rise
    cs_start();
    xfer(8'h23, 8, rx, oe_or, oe_and);
    xfer(8'h88, 8, rx, oe_or, oe_and);
    cs_end();
    check("bdu_ctrl4", {24'd0, ctrl_reg4}, 32'h88);
    cs_start();
    xfer(8'hE8, 8, rx, oe_or, oe_and);
    pulse_sample(16'hBABA, 16'h0000, 16'h0000);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("bdu_old_x_l", {24'd0, rx}, 32'h9A);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("bdu_old_x_h", {24'd0, rx}, 32'h12);
    cs_end();
    cs_start();
    xfer(8'hE8, 8, rx, oe_or, oe_and);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("bdu_new_x_l", {24'd0, rx}, 32'hBA);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("bdu_new_x_h", {24'd0, rx}, 32'hBA);
    cs_end();

    // MS=0 multi-byte write overwrites the same register
    cs_start();
    xfer(8'h20, 8, rx, oe_or, oe_and);
    xfer(8'h11, 8, rx, oe_or, oe_and);
    xfer(8'h22, 8, rx, oe_or, oe_and);
    cs_end();
    check("ms0_ctrl1", {24'd0, ctrl_reg1}, 32'h22);
    check("ms0_temp", {24'd0, temp_cfg}, 32'h5A);

    // Partial data byte is discarded
    cs_start();
    xfer(8'h1F, 8, rx, oe_or, oe_and);
    xfer(8'hF0, 4, rx, oe_or, oe_and);
    cs_end();
    check("partial_temp", {24'd0, temp_cfg}, 32'h5A);

    // Empty frame still pulses frame_done
    fd0 = fd_cnt;
    cs_start();
    cs_end();
    check("empty_fdone", fd_cnt, fd0 + 1);

    // Asynchronous reset in the middle of a read byte
    cs_start();
    xfer(8'hA0, 8, rx, oe_or, oe_and);
    xfer(8'h00, 3, rx, oe_or, oe_and);
    check("midrd_oe_before", {31'd0, spi_miso_oe}, 32'd1);
    nrst = 1'b0;
    #1;
    check("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("midrst_miso", {31'd0, spi_miso}, 32'd0);
    check("midrst_ctrl1", {24'd0, ctrl_reg1}, 32'h07);
    check("midrst_temp", {24'd0, temp_cfg}, 32'h00);
    check("midrst_ctrl4", {24'd0, ctrl_reg4}, 32'h00);
    spi_cs_n = 1'b1;
    spi_sck = 1'b1;
    wait_clk(3);
    nrst = 1'b1;
    wait_clk(4);
    cs_start();
    xfer(8'hE8, 8, rx, oe_or, oe_and);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("postrst_x_l", {24'd0, rx}, 32'h00);
    cs_end();
    cs_start();
    xfer(8'hA0, 8, rx, oe_or, oe_and);
    xfer(8'h00, 8, rx, oe_or, oe_and);
    check("postrst_ctrl1_rd", {24'd0, rx}, 32'h07);
    cs_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
